interleaver_branch_ctrl: RTL and testbench



---
 rtl/interleaver_pkg.sv | 25 ++
 rtl/interleaver_branch_ctrl_if.sv | 25 ++
 rtl/interleaver_out_slot.sv | 41 ++++
 rtl/interleaver_branch_ctrl.sv | 110 +++++++++++
 tb/tb_interleaver_branch_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/interleaver_pkg.sv
// Shared constants, state type and sync-byte helper for the interleaver
// branch sequencer.
package interleaver_pkg;

    localparam int NUM_BRANCH = 12;
    localparam int PKT_LEN    = 204;
    localparam int MISS_MAX   = 3;
    localparam int SEL_W      = 4;
    localparam int MISS_W     = 2;
    localparam int BYTE_CNT_W = $clog2(PKT_LEN);

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] SYNC_INV  = 8'hB8;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } sync_state_t;

    // Both polarities of the sync byte count as a packet boundary marker.
    function automatic logic is_sync(input logic [7:0] b);
        return (b == SYNC_BYTE) || (b == SYNC_INV);
    endfunction

endpackage

// File: rtl/interleaver_branch_ctrl_if.sv
// Byte-stream handshake and demux-side bus of the interleaver branch sequencer.
interface interleaver_branch_ctrl_if;

    logic [7:0]                      data_in;
    logic                            in_valid;
    logic                            in_ready;
    logic                            out_ready;
    logic [7:0]                      data_out;
    logic [interleaver_pkg::SEL_W-1:0] sel;
    logic                            out_valid;
    logic                            pkt_start;
    logic                            locked;
    logic [interleaver_pkg::MISS_W-1:0] miss_cnt;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, sel, out_valid, pkt_start, locked, miss_cnt
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, sel, out_valid, pkt_start, locked, miss_cnt
    );

endinterface

// File: rtl/interleaver_out_slot.sv
// Single-entry valid/ready output register holding byte, branch select and
// packet-start flag for the demux.
module interleaver_out_slot
    import interleaver_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [7:0]       load_data,
    input  logic [SEL_W-1:0] load_sel,
    input  logic             load_pkt_start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       data_out,
    output logic [SEL_W-1:0] sel,
    output logic             pkt_start,
    output logic             in_ready
);

    assign in_ready = ~out_valid | out_ready;

    // A load wins over a drain so a same-cycle drain+accept keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= 8'h00;
            sel       <= '0;
            pkt_start <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_out  <= load_data;
            sel       <= load_sel;
            pkt_start <= load_pkt_start;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            sel       <= '0;
            pkt_start <= 1'b0;
        end
    end

endmodule

// File: rtl/interleaver_branch_ctrl.sv
// Sync hunt/lock FSM and branch/byte commutation counters feeding the
// 12-branch interleaver demux through a registered output slot.
module interleaver_branch_ctrl
    import interleaver_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    interleaver_branch_ctrl_if.slave  bus
);

    sync_state_t           state, state_n;
    logic [SEL_W-1:0]      branch_cnt, branch_n;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_n;
    logic [MISS_W-1:0]     miss_cnt, miss_n;

    logic                  slot_in_ready;
    logic                  accept;
    logic                  byte_is_sync;
    logic                  load;
    logic [SEL_W-1:0]      load_sel;
    logic                  load_pkt_start;
    logic [MISS_W:0]       miss_inc;

    assign accept       = bus.in_valid & slot_in_ready;
    assign byte_is_sync = is_sync(bus.data_in);
    assign miss_inc     = {1'b0, miss_cnt} + {{MISS_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            branch_cnt <= SEL_W'(1);
            byte_cnt   <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_n;
            branch_cnt <= branch_n;
            byte_cnt   <= byte_n;
            miss_cnt   <= miss_n;
        end
    end

    // Everything holds unless a byte is accepted, so stalls freeze the counters.
    always_comb begin
        state_n        = state;
        branch_n       = branch_cnt;
        byte_n         = byte_cnt;
        miss_n         = miss_cnt;
        load           = 1'b0;
        load_sel       = branch_cnt;
        load_pkt_start = 1'b0;

        case (state)
            HUNT: begin
                if (accept && byte_is_sync) begin
                    load           = 1'b1;
                    load_sel       = SEL_W'(1);
                    load_pkt_start = 1'b1;
                    byte_n         = BYTE_CNT_W'(1);
                    branch_n       = SEL_W'(2);
                    miss_n         = '0;
                    state_n        = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    load           = 1'b1;
                    load_pkt_start = (byte_cnt == '0);
                    branch_n       = (branch_cnt == SEL_W'(NUM_BRANCH)) ?
                                     SEL_W'(1) : branch_cnt + SEL_W'(1);
                    byte_n         = (byte_cnt == BYTE_CNT_W'(PKT_LEN - 1)) ?
                                     '0 : byte_cnt + BYTE_CNT_W'(1);
                    // Packet boundary: a missing sync byte counts toward losing lock.
                    if (byte_cnt == '0) begin
                        if (byte_is_sync) begin
                            miss_n = '0;
                        end else if (miss_inc == (MISS_W+1)'(MISS_MAX)) begin
                            state_n  = HUNT;
                            miss_n   = '0;
                            branch_n = SEL_W'(1);
                            byte_n   = '0;
                        end else begin
                            miss_n = miss_inc[MISS_W-1:0];
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    interleaver_out_slot u_out_slot (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .load_data      (bus.data_in),
        .load_sel       (load_sel),
        .load_pkt_start (load_pkt_start),
        .out_ready      (bus.out_ready),
        .out_valid      (bus.out_valid),
        .data_out       (bus.data_out),
        .sel            (bus.sel),
        .pkt_start      (bus.pkt_start),
        .in_ready       (slot_in_ready)
    );

    assign bus.in_ready = slot_in_ready;
    assign bus.locked   = (state == LOCK);
    assign bus.miss_cnt = miss_cnt;

endmodule

// File: tb/tb_interleaver_branch_ctrl.sv
// Scoreboard bench for interleaver_branch_ctrl: directed byte vectors push
// expected outputs; a monitor pops and compares on each output transfer.
module tb_interleaver_branch_ctrl;

    typedef struct {
        logic [7:0] d;
        logic [3:0] s;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    interleaver_branch_ctrl_if bus();

    interleaver_branch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Offer one byte; push the expected slot contents at the accepting edge.
    task automatic applyStimulus(input logic [7:0] b, input bit fwd, input logic [3:0] s, input bit p);
        int  waited = 0;
        bit  done = 0;
        bus.data_in  = b;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL accept_timeout: byte %0h never accepted, required accept within 50 cycles", b);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        if (fwd) exp_q.push_back('{d: b, s: s, p: p});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sendBody();
        for (int i = 1; i < 204; i++)
            applyStimulus(8'(i), 1'b1, 4'((i % 12) + 1), 1'b0);
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid&ready here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_out: data=%0h sel=%0d, required no output", bus.data_out, bus.sel);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data_out !== e.d || bus.sel !== e.s || bus.pkt_start !== e.p) begin
                        errors++;
                        $display("[TB] FAIL out_byte: data=%0h sel=%0d pkt=%b, required data=%0h sel=%0d pkt=%b",
                                 bus.data_out, bus.sel, bus.pkt_start, e.d, e.s, e.p);
                    end
                end
                if (bus.pkt_start) checkOutput("pkt_start_sel", 32'(bus.sel), 32'd1);
            end else if (rst_n && !bus.out_valid) begin
                checkOutput("idle_sel", 32'(bus.sel), 32'd0);
            end
        end
    end

    initial begin
        bus.data_in   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sel", 32'(bus.sel), 32'd0);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("rst_pkt_start", 32'(bus.pkt_start), 32'd0);
        checkOutput("rst_locked", 32'(bus.locked), 32'd0);
        checkOutput("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] hunt: non-sync bytes dropped");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b0, 4'd0, 1'b0);
            checkOutput("hunt_in_ready", 32'(bus.in_ready), 32'd1);
            checkOutput("hunt_locked", 32'(bus.locked), 32'd0);
        end

        $display("[TB] lock on 0x47 and commutate");
        applyStimulus(8'h12, 1'b0, 4'd0, 1'b0);
        applyStimulus(8'h47, 1'b1, 4'd1, 1'b1);
        checkOutput("lock_locked", 32'(bus.locked), 32'd1);
        checkOutput("lock_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        sendBody();

        $display("[TB] inverted sync accepted");
        applyStimulus(8'hB8, 1'b1, 4'd1, 1'b1);
        checkOutput("inv_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        checkOutput("inv_locked", 32'(bus.locked), 32'd1);
        sendBody();

        $display("[TB] three missed syncs drop lock");
        applyStimulus(8'h00, 1'b1, 4'd1, 1'b1);
        checkOutput("miss1_cnt", 32'(bus.miss_cnt), 32'd1);
        sendBody();
        applyStimulus(8'h00, 1'b1, 4'd1, 1'b1);
        checkOutput("miss2_cnt", 32'(bus.miss_cnt), 32'd2);
        checkOutput("miss2_locked", 32'(bus.locked), 32'd1);
        sendBody();
        applyStimulus(8'h00, 1'b1, 4'd1, 1'b1);
        checkOutput("miss3_locked", 32'(bus.locked), 32'd0);
        checkOutput("miss3_cnt", 32'(bus.miss_cnt), 32'd0);
        applyStimulus(8'h00, 1'b0, 4'd0, 1'b0);
        applyStimulus(8'h12, 1'b0, 4'd0, 1'b0);
        applyStimulus(8'h34, 1'b0, 4'd0, 1'b0);
        checkOutput("post_loss_locked", 32'(bus.locked), 32'd0);

        $display("[TB] output stall");
        applyStimulus(8'h47, 1'b1, 4'd1, 1'b1);
        for (int i = 1; i <= 5; i++)
            applyStimulus(8'(i), 1'b1, 4'(i + 1), 1'b0);
        bus.out_ready = 1'b0;
        bus.data_in   = 8'h06;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_data", 32'(bus.data_out), 32'h05);
            checkOutput("stall_sel", 32'(bus.sel), 32'd6);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(8'h06, 1'b1, 4'd7, 1'b0);
        for (int i = 7; i <= 9; i++)
            applyStimulus(8'(i), 1'b1, 4'(i + 1), 1'b0);

        $display("[TB] async reset mid-packet");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("areset_sel", 32'(bus.sel), 32'd0);
        checkOutput("areset_locked", 32'(bus.locked), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'h47, 1'b1, 4'd1, 1'b1);
        checkOutput("relock_locked", 32'(bus.locked), 32'd1);
        applyStimulus(8'h01, 1'b1, 4'd2, 1'b0);
        applyStimulus(8'h02, 1'b1, 4'd3, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("drained_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
